amp_agc_ctrl: RTL and testbench

- Digital controller that sequences power-up of the RNM amplifier and runs automatic gain control on it.
- Drives the amplifier `en` and `amp[1:0]` from a clocked FSM.
- Input 1: a supply-good flag, `vdd_ok`, from a threshold detector on `vdd`.
- Input 2: two per-sample level flags, `out_high` and `out_low`, from comparators on the amplifier `out`.
- Sits between the system start/stop control and the amplifier, in the same sampled-clock domain as the input stimulus.

---
 rtl/amp_agc_ctrl_if.sv | 25 ++
 rtl/amp_agc_ctrl.sv | 174 +++++++++++++++++
 tb/tb_amp_agc_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/amp_agc_ctrl_if.sv
// Signal bundle between the system/amplifier side and the AGC controller.
// The master drives control requests and comparator flags and observes status.
// The slave is the controller.
interface amp_agc_ctrl_if;
  logic       start;
  logic       stop;
  logic       vdd_ok;
  logic       out_high;
  logic       out_low;
  logic       en;
  logic [1:0] amp;
  logic       ready;
  logic       fault;
  logic [1:0] state;

  modport master (
    output start, stop, vdd_ok, out_high, out_low,
    input  en, amp, ready, fault, state
  );

  modport slave (
    input  start, stop, vdd_ok, out_high, out_low,
    output en, amp, ready, fault, state
  );
endinterface

// File: rtl/amp_agc_ctrl.sv
// Power-up sequencer and automatic gain controller for the RNM amplifier.
// The controller waits for a debounced supply-good flag, then enables the
// amplifier at the initial gain. It lets the output settle, and then watches
// the level comparators over fixed windows. After each window it steps the
// gain down on any overload, or up when the output was low for the whole
// window. One shared counter serves debounce, settle and window timing,
// because only one of those phases is ever active.
module amp_agc_ctrl #(
  parameter int unsigned VDD_DEB    = 4,
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned WIN        = 16,
  parameter logic [1:0]  INIT_AMP   = 2'b00
) (
  input  logic          clk,
  input  logic          rst,
  amp_agc_ctrl_if.slave agc_if
);

  localparam int unsigned MAX_AB = (VDD_DEB > SETTLE_CYC) ? VDD_DEB : SETTLE_CYC;
  localparam int unsigned MAX_N  = (MAX_AB > WIN) ? MAX_AB : WIN;
  localparam int unsigned CW     = $clog2(MAX_N + 1);

  localparam logic [CW-1:0] DEB_LAST = CW'(VDD_DEB - 1);
  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] WIN_LAST = CW'(WIN - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_WAIT_VDD = 2'd1,
    ST_SETTLE   = 2'd2,
    ST_TRACK    = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    amp_q, amp_d;
  logic          fault_q, fault_d;
  logic          en_q, en_d;
  logic          ready_q, ready_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          any_high_q, any_high_d;
  logic          all_low_q, all_low_d;
  logic          hi_s;
  logic          lo_s;
  logic          abort_s;

  // Saturating increment: counters hold at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CW'(1);
    end
  endfunction

  // Window flags including the current sample; a sample that is both high
  // and low counts as high only.
  always_comb begin
    hi_s    = any_high_q | agc_if.out_high;
    lo_s    = all_low_q & agc_if.out_low & ~agc_if.out_high;
    abort_s = agc_if.stop | ~agc_if.vdd_ok;
  end

  // Next-state, gain and fault decisions for every phase of the sequence.
  always_comb begin
    state_d    = state_q;
    amp_d      = amp_q;
    fault_d    = fault_q;
    cnt_d      = cnt_q;
    any_high_d = any_high_q;
    all_low_d  = all_low_q;
    case (state_q)
      ST_OFF: begin
        if (agc_if.start && !agc_if.stop) begin
          state_d = ST_WAIT_VDD;
          fault_d = 1'b0;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_OFF;
        end
      end
      ST_WAIT_VDD: begin
        if (agc_if.stop) begin
          state_d = ST_OFF;
        end else if (agc_if.vdd_ok) begin
          if (cnt_q == DEB_LAST) begin
            state_d = ST_SETTLE;
            amp_d   = INIT_AMP;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end else begin
          cnt_d = CNT_ZERO;
        end
      end
      ST_SETTLE: begin
        if (abort_s) begin
          state_d = ST_OFF;
          fault_d = fault_q | ~agc_if.vdd_ok;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == SET_LAST) begin
          state_d    = ST_TRACK;
          cnt_d      = CNT_ZERO;
          any_high_d = 1'b0;
          all_low_d  = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_TRACK: begin
        if (abort_s) begin
          state_d = ST_OFF;
          fault_d = fault_q | ~agc_if.vdd_ok;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == WIN_LAST) begin
          cnt_d      = CNT_ZERO;
          any_high_d = 1'b0;
          all_low_d  = 1'b1;
          if (hi_s && (amp_q != 2'd0)) begin
            amp_d   = amp_q - 2'd1;
            state_d = ST_SETTLE;
          end else if (lo_s && (amp_q != 2'd3)) begin
            amp_d   = amp_q + 2'd1;
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_TRACK;
          end
        end else begin
          cnt_d      = sat_inc(cnt_q);
          any_high_d = hi_s;
          all_low_d  = lo_s;
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = CNT_ZERO;
      end
    endcase
    en_d    = (state_d == ST_SETTLE) || (state_d == ST_TRACK);
    ready_d = (state_d == ST_TRACK);
  end

  // State, counters and registered outputs; synchronous reset wins over all.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_OFF;
      amp_q      <= INIT_AMP;
      fault_q    <= 1'b0;
      en_q       <= 1'b0;
      ready_q    <= 1'b0;
      cnt_q      <= CNT_ZERO;
      any_high_q <= 1'b0;
      all_low_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      amp_q      <= amp_d;
      fault_q    <= fault_d;
      en_q       <= en_d;
      ready_q    <= ready_d;
      cnt_q      <= cnt_d;
      any_high_q <= any_high_d;
      all_low_q  <= all_low_d;
    end
  end

  assign agc_if.en    = en_q;
  assign agc_if.amp   = amp_q;
  assign agc_if.ready = ready_q;
  assign agc_if.fault = fault_q;
  assign agc_if.state = state_q;

endmodule

// File: tb/tb_amp_agc_ctrl.sv
// Bench for amp_agc_ctrl: directed power-up/AGC scenario with literal
// expectations, then randomized phases, all checked every cycle against a
// count-based behavioural model.
module tb_amp_agc_ctrl;
  localparam int VDD_DEB    = 4;
  localparam int SETTLE_CYC = 8;
  localparam int WIN        = 16;
  localparam int INIT_AMP   = 0;

  logic clk = 1'b0;
  logic rst;
  amp_agc_ctrl_if agc_if();

  amp_agc_ctrl dut (.clk(clk), .rst(rst), .agc_if(agc_if));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Behavioural model: mode 0=off 1=waiting for supply 2=settling 3=tracking
  int m_mode, m_amp, m_fault;
  int m_ones;      // consecutive good-supply samples while waiting
  int m_elapsed;   // settle cycles elapsed
  int m_samples;   // samples taken in the current window
  int m_highs;     // samples in window with out_high
  int m_lows;      // samples in window that were low and not high

  task automatic model_update();
    if (rst) begin
      m_mode = 0; m_amp = INIT_AMP; m_fault = 0;
      m_ones = 0; m_elapsed = 0; m_samples = 0; m_highs = 0; m_lows = 0;
    end else if (m_mode == 0) begin
      if (agc_if.start && !agc_if.stop) begin
        m_mode = 1; m_fault = 0; m_ones = 0;
      end
    end else if (m_mode == 1) begin
      if (agc_if.stop) m_mode = 0;
      else if (!agc_if.vdd_ok) m_ones = 0;
      else begin
        m_ones++;
        if (m_ones >= VDD_DEB) begin
          m_mode = 2; m_amp = INIT_AMP; m_elapsed = 0;
        end
      end
    end else begin
      if (!agc_if.vdd_ok || agc_if.stop) begin
        if (!agc_if.vdd_ok) m_fault = 1;
        m_mode = 0;
      end else if (m_mode == 2) begin
        m_elapsed++;
        if (m_elapsed == SETTLE_CYC) begin
          m_mode = 3; m_samples = 0; m_highs = 0; m_lows = 0;
        end
      end else begin
        m_samples++;
        if (agc_if.out_high) m_highs++;
        else if (agc_if.out_low) m_lows++;
        if (m_samples == WIN) begin
          if (m_highs > 0 && m_amp > 0) begin
            m_amp--; m_mode = 2; m_elapsed = 0;
          end else if (m_lows == WIN && m_amp < 3) begin
            m_amp++; m_mode = 2; m_elapsed = 0;
          end
          m_samples = 0; m_highs = 0; m_lows = 0;
        end
      end
    end
  endtask

  function automatic logic [6:0] dut_outs();
    return {agc_if.en, agc_if.amp, agc_if.ready, agc_if.fault, agc_if.state};
  endfunction

  function automatic logic [6:0] model_outs();
    logic [1:0] a, s;
    a = 2'(m_amp);
    s = 2'(m_mode);
    return {(m_mode >= 2), a, (m_mode == 3), (m_fault != 0), s};
  endfunction

  task automatic check_lit(input string name, input logic [6:0] got, input logic [6:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s cyc%0d got %b want %b", name, cyc, got, want);
    end
  endtask

  // One clock: inputs already driven, advance, update model, compare.
  task automatic step();
    logic [6:0] g, w;
    @(posedge clk);
    model_update();
    #1;
    g = dut_outs();
    w = model_outs();
    n_vec++;
    if (g !== w) begin
      n_err++;
      $display("FAIL model cyc%0d got en/amp/rdy/flt/st=%b want %b", cyc, g, w);
    end
  endtask

  task automatic drive_directed(input int c);
    rst             = (c < 2) || (c == 188);
    agc_if.start    = (c == 5) || (c == 137) || (c == 180) || (c == 181);
    agc_if.stop     = (c == 180);
    agc_if.vdd_ok   = (c >= 7) && (c != 135) && (c != 141);
    agc_if.out_low  = ((c >= 19) && (c <= 122)) || ((c >= 154) && (c <= 169));
    agc_if.out_high = (c == 114);
  endtask

  // Hand-computed expectations; field order en,amp[1:0],ready,fault,state[1:0]
  task automatic directed_checks(input int c);
    logic [6:0] o;
    o = dut_outs();
    case (c)
      1:   check_lit("reset",        o,                       7'b0_00_0_0_00);
      5:   check_lit("start_wait",   {5'b0, o[1:0]},          7'b0_00_0_0_01);
      9:   check_lit("deb_not_yet",  {o[6], 6'b0},            7'b0_00_0_0_00);
      10:  check_lit("enable",       o,                       7'b1_00_0_0_10);
      17:  check_lit("settle_end",   o,                       7'b1_00_0_0_10);
      18:  check_lit("track",        o,                       7'b1_00_1_0_11);
      34:  check_lit("gain_up1",     o,                       7'b1_01_0_0_10);
      58:  check_lit("gain_up2",     o,                       7'b1_10_0_0_10);
      82:  check_lit("gain_up3",     o,                       7'b1_11_0_0_10);
      106: check_lit("gain_sat",     o,                       7'b1_11_1_0_11);
      122: check_lit("gain_down",    o,                       7'b1_10_0_0_10);
      135: check_lit("supply_fault", o,                       7'b0_10_0_1_00);
      137: check_lit("fault_clear",  {2'b0, o[4], 1'b0, o[2:0]}, 7'b0_00_0_0_01);
      144: check_lit("glitch_wait",  o,                       7'b0_10_0_0_01);
      145: check_lit("glitch_en",    o,                       7'b1_00_0_0_10);
      180: check_lit("stop_prio",    o,                       7'b0_01_0_0_00);
      181: check_lit("rearm",        o,                       7'b0_01_0_0_01);
      185: check_lit("resettle",     o,                       7'b1_00_0_0_10);
      188: check_lit("reset_mid",    o,                       7'b0_00_0_0_00);
      default: ;
    endcase
  endtask

  initial begin
    int hi_pct[4]   = '{0, 2, 30, 50};
    int lo_pct[4]   = '{100, 97, 60, 50};
    int stop_div[4] = '{300, 300, 150, 20};
    int vdd_div[4]  = '{200, 200, 100, 10};
    m_mode = 0; m_amp = INIT_AMP; m_fault = 0;
    m_ones = 0; m_elapsed = 0; m_samples = 0; m_highs = 0; m_lows = 0;
    for (int c = 0; c < 190; c++) begin
      cyc = c;
      drive_directed(c);
      step();
      directed_checks(c);
    end
    for (int ph = 0; ph < 4; ph++) begin
      for (int k = 0; k < 1500; k++) begin
        cyc++;
        rst             = ($urandom_range(0, 499) == 0);
        agc_if.start    = ($urandom_range(0, 7) == 0);
        agc_if.stop     = ($urandom_range(0, stop_div[ph] - 1) == 0);
        agc_if.vdd_ok   = ($urandom_range(0, vdd_div[ph] - 1) != 0);
        agc_if.out_high = ($urandom_range(0, 99) < hi_pct[ph]);
        agc_if.out_low  = ($urandom_range(0, 99) < lo_pct[ph]);
        step();
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
